// File: rtl/pc_counter.sv
// Program counter: a WIDTH-bit register that advances by STEP on enabled cycles
// and reloads RESET_VAL on a synchronous, active-high reset.
module pc_counter #(
    parameter int unsigned WIDTH     = 9,
    parameter int unsigned RESET_VAL = 0,
    parameter int unsigned STEP      = 1
) (
    input  logic             Clock,
    input  logic             PcEn,
    output logic [WIDTH-1:0] PC,
    input  logic             Reset
);

    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

    // The initialiser gives tied-low-reset instances a defined start value.
    logic [WIDTH-1:0] pc_q = RESET_W;
    logic [WIDTH-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (Reset) begin
            pc_d = RESET_W;
        end else if (PcEn) begin
            pc_d = pc_q + STEP_W;
        end
    end

    always_ff @(posedge Clock) begin
        pc_q <= pc_d;
    end

    assign PC = pc_q;

endmodule

// File: tb/tb_pc_counter.sv
// Self-checking bench for pc_counter (default parameters): expected PC values
// are pushed by the stimulus side and popped after each rising edge.
module tb_pc_counter;

    logic       Clock = 1'b0;
    logic       PcEn  = 1'b0;
    logic       Reset = 1'b0;
    logic [8:0] PC;

    int checks = 0;
    int passed = 0;

    logic [8:0] model_pc = 9'd0;
    logic [8:0] exp_q[$];

    always #5 Clock = ~Clock;

    pc_counter dut (
        .Clock(Clock),
        .PcEn (PcEn),
        .PC   (PC),
        .Reset(Reset)
    );

    // Drive one cycle of stimulus on the falling edge, record the expected
    // result, and return 1 time unit after the following rising edge.
    task automatic drive_edge(input logic en, input logic rst);
        @(negedge Clock);
        PcEn  = en;
        Reset = rst;
        if (rst)
            model_pc = 9'd0;
        else if (en)
            model_pc = model_pc + 9'd1;
        exp_q.push_back(model_pc);
        @(posedge Clock);
        #1;
    endtask

    task automatic test_init;
        #1;
        checks++;
        if (PC !== 9'd0)
            $display("FAIL init: PC=%0d required=0", PC);
        else begin
            passed++;
            $display("init: PC=%0d", PC);
        end
    endtask

    task automatic test_reset;
        logic [8:0] e;
        drive_edge(1'b1, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (PC !== e || PC !== 9'd0)
            $display("FAIL reset: PC=%0d required=%0d", PC, e);
        else begin
            passed++;
            $display("reset: PC=%0d", PC);
        end
    endtask

    task automatic test_count;
        logic [8:0] e;
        for (int i = 1; i <= 7; i++) begin
            drive_edge(1'b1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (PC !== e || PC !== 9'(i))
                $display("FAIL count[%0d]: PC=%0d required=%0d", i, PC, e);
            else begin
                passed++;
                $display("count[%0d]: PC=%0d", i, PC);
            end
        end
    endtask

    task automatic test_toggle;
        logic [8:0] e;
        logic [3:0] pattern;
        pattern = 4'b1001;
        drive_edge(1'b0, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b1, 1'b0);
            void'(exp_q.pop_front());
        end
        checks++;
        if (PC !== 9'd3)
            $display("FAIL toggle_start: PC=%0d required=3", PC);
        else
            passed++;
        for (int i = 0; i < 4; i++) begin
            drive_edge(pattern[3-i], 1'b0);
            e = exp_q.pop_front();
            checks++;
            if (PC !== e)
                $display("FAIL toggle[%0d]: PC=%0d required=%0d", i, PC, e);
            else begin
                passed++;
                $display("toggle[%0d]: en=%0b PC=%0d", i, pattern[3-i], PC);
            end
        end
    endtask

    task automatic test_wrap;
        logic [8:0] e;
        drive_edge(1'b0, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 511; i++) begin
            drive_edge(1'b1, 1'b0);
            void'(exp_q.pop_front());
        end
        checks++;
        if (PC !== 9'd511)
            $display("FAIL wrap_preload: PC=%0d required=511", PC);
        else begin
            passed++;
            $display("wrap_preload: PC=%0d", PC);
        end
        drive_edge(1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (PC !== e || PC !== 9'd0)
            $display("FAIL wrap: PC=%0d required=%0d", PC, e);
        else begin
            passed++;
            $display("wrap: PC=%0d", PC);
        end
    endtask

    task automatic test_reset_priority;
        logic [8:0] e;
        drive_edge(1'b0, 1'b1);
        void'(exp_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            drive_edge(1'b1, 1'b0);
            void'(exp_q.pop_front());
        end
        checks++;
        if (PC !== 9'd5)
            $display("FAIL prio_start: PC=%0d required=5", PC);
        else
            passed++;
        drive_edge(1'b1, 1'b1);
        e = exp_q.pop_front();
        checks++;
        if (PC !== e || PC !== 9'd0)
            $display("FAIL prio_reset: PC=%0d required=%0d", PC, e);
        else begin
            passed++;
            $display("prio_reset: PC=%0d", PC);
        end
        drive_edge(1'b1, 1'b0);
        e = exp_q.pop_front();
        checks++;
        if (PC !== e || PC !== 9'd1)
            $display("FAIL prio_resume: PC=%0d required=%0d", PC, e);
        else begin
            passed++;
            $display("prio_resume: PC=%0d", PC);
        end
    endtask

    // Pulses that start after a falling edge and end before the next rising
    // edge must never be seen by the counter.
    task automatic test_between_edges;
        logic [8:0] held;
        held = PC;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            PcEn = 1'b1;
            #2;
            PcEn = 1'b0;
            @(posedge Clock);
            #1;
            checks++;
            if (PC !== held)
                $display("FAIL glitch_en[%0d]: PC=%0d required=%0d", i, PC, held);
            else begin
                passed++;
                $display("glitch_en[%0d]: PC=%0d", i, PC);
            end
        end
        @(negedge Clock);
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        checks++;
        if (PC !== held)
            $display("FAIL glitch_rst: PC=%0d required=%0d", PC, held);
        else begin
            passed++;
            $display("glitch_rst: PC=%0d", PC);
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] e;
        for (int i = 0; i < 20; i++) begin
            drive_edge(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
            e = exp_q.pop_front();
            checks++;
            if (PC !== e)
                $display("FAIL random[%0d]: PC=%0d required=%0d", i, PC, e);
            else begin
                passed++;
                $display("random[%0d]: en=%0b rst=%0b PC=%0d", i, PcEn, Reset, PC);
            end
        end
    endtask

    initial begin
        test_init();
        test_reset();
        test_count();
        test_toggle();
        test_wrap();
        test_reset_priority();
        test_between_edges();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pc_counter.md
PC_COUNTER -- requirements
Module: pc_counter

Interface
REQ-001 Parameter WIDTH, default 9: bit width of the program counter.
REQ-002 Parameter RESET_VAL, default 0: value loaded into PC on reset.
REQ-003 Parameter STEP, default 1: increment applied per enabled cycle, interpreted as unsigned WIDTH bits.
REQ-004 Port Clock  input  1  single system clock; all state updates occur on its rising edge.
REQ-005 Port Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clock.
REQ-006 Port PcEn  input  1  count enable; when high at a rising edge, PC advances by STEP.
REQ-007 Port PC  output  WIDTH  registered program-counter value.
REQ-008 Positional port order SHALL be Clock, PcEn, PC, Reset, so that existing three-port positional instantiations of the form (Clock, PcEn, PC) stay valid.
REQ-009 There SHALL be no other clock, no asynchronous reset, and no combinational path from any input to PC.

Function
REQ-010 PC SHALL be a register updated only on the rising edge of Clock.
REQ-011 At a rising edge with Reset=1, PC SHALL become RESET_VAL regardless of PcEn.
REQ-012 At a rising edge with Reset=0 and PcEn=1, PC SHALL become (PC + STEP) mod 2^WIDTH.
REQ-013 At a rising edge with Reset=0 and PcEn=0, PC SHALL hold its value.
REQ-014 Latency: a PcEn pulse sampled at edge N SHALL be visible on PC immediately after edge N, i.e. one register stage.
REQ-015 PcEn may be driven on the falling edge by the upstream instruction queue; the counter SHALL use only the value present at the rising edge.
REQ-016 Wrap-around: from 2^WIDTH-1 with STEP=1 and PcEn=1, PC SHALL become 0, with no error flag and no saturation.
REQ-017 Simultaneous Reset=1 and PcEn=1 SHALL give RESET_VAL; reset has priority.
REQ-018 Reset asserted mid-count SHALL take effect at the next rising edge; counting SHALL resume from RESET_VAL on the first edge with Reset=0 and PcEn=1.
REQ-019 PcEn held high for k consecutive edges SHALL advance PC by exactly k*STEP (mod 2^WIDTH); there SHALL be no skipped or double counts.
REQ-020 PcEn or Reset changing between rising edges SHALL NOT change PC.
REQ-021 Arithmetic SHALL be unsigned, truncated to WIDTH bits.

Reset
REQ-022 Reset value of PC SHALL be RESET_VAL, 0 by default.
REQ-023 For simulation, PC SHALL initialise to RESET_VAL at time zero, so that instances with Reset left tied low start at 0.
REQ-024 Reset SHALL be the only means of loading PC; there is no parallel load port.

Verification
REQ-025 Reset=1 for 1 edge with PcEn=1 -> PC=0 after the edge.
REQ-026 Reset=0, PcEn=1 for 7 edges starting from 0 -> PC goes 1,2,...,7, one step per edge.
REQ-027 PcEn toggled 1,0,0,1 over 4 edges from PC=3 -> PC goes 4,4,4,5.
REQ-028 Preload via repeated enables to PC=511 (WIDTH=9), then PcEn=1 for one edge -> PC=0.
REQ-029 PC=5, Reset=1 and PcEn=1 asserted at the same edge -> PC=0; next edge with Reset=0 and PcEn=1 -> PC=1.
REQ-030 PcEn pulsed high only between rising edges (driven on negedge, deasserted before the next posedge) -> PC unchanged.
